hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Central hazard unit for the 5-stage MIPS pipeline; produces the 2-bit forwarding selects consumed by the D/E/M forwarding muxes, plus the D-stage stall.
- Tracks destination register and remaining Tnew of every in-flight instruction in E/M/W, and a multiply/divide busy counter.
- Inputs come from D-stage decode; outputs go to the forwarding muxes and to the F/D-freeze and E-bubble controls.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu enters E
- DIV_CYCLES, 10, busy cycles after div/divu enters E

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  exception/eret flush; clears tracked E/M/W records
- d_rs  in  5  D-stage rs index
- d_rt  in  5  D-stage rt index
- d_tuse_rs  in  2  cycles until D needs rs; 3 = unused
- d_tuse_rt  in  2  cycles until D needs rt; 3 = unused
- d_dst  in  5  D-stage destination register; 0 = none
- d_tnew  in  2  cycles after entering E until result ready (0..2)
- d_md_start  in  1  D is mult/multu/div/divu
- d_md_is_div  in  1  selects DIV_CYCLES when d_md_start
- d_md_use  in  1  D reads/writes HI/LO or starts md
- stall  out  1  freeze PC and F/D; bubble into E
- fwd_d_rs, fwd_d_rt  out  2  select for D muxes
- fwd_e_rs, fwd_e_rt  out  2  select for E muxes
- fwd_m_rt  out  2  select for M store-data mux

Behaviour:
- Internal records E, M, W: {dst[4:0], tnew[1:0], rs, rt, md_start, md_is_div}. Reset or flush: all fields 0 on next edge.
- Each edge, no stall: E<=D inputs; M<=E with tnew=sat(E.tnew-1); W<=M with tnew=sat(M.tnew-1).
- Each edge, stall: E<=bubble (all 0); M and W advance as above.
- Stall (combinational) = stall_rs | stall_rt | stall_md.
  - stall_rs: d_rs!=0 and d_tuse_rs!=3 and ((E.dst==d_rs and d_tuse_rs<E.tnew) or (M.dst==d_rs and d_tuse_rs<M.tnew)). stall_rt is the same with rt.
  - stall_md: d_md_use and (busy_cnt!=0 or E.md_start).
- D selects, nearest stage wins:
  - E.dst==reg and reg!=0 and E.tnew==0 -> FWD_EREG_TO_D.
  - else M.dst==reg and M.tnew==0 -> FWD_MREG_TO_D.
  - else FWD_DONT_FWD. The W stage is covered by GRF write-through, so no W code here.
- E selects on E.rs/E.rt:
  - M.dst match and M.tnew==0 -> FWD_MREG_TO_E.
  - else W.dst match -> FWD_WREG_TO_E.
  - else FWD_DONT_FWD.
- M select on M.rt: W.dst match -> FWD_WREG_TO_M, else FWD_DONT_FWD.
- Register 0 never matches.
- busy_cnt:
  - Reset to 0.
  - When E.md_start, load MULT_CYCLES or DIV_CYCLES on that edge.
  - Otherwise decrement to 0 and saturate.
  - flush does not clear it, because the md hardware keeps running.
- Reset values: all outputs 0 (FWD_DONT_FWD, stall=0) from the first cycle after reset.
- Simultaneous reset and flush: reset dominates, identical result except busy_cnt also clears.
- Simultaneous stall and flush: flush wins, records clear.
- Outputs are purely combinational from records plus D inputs; there is no added latency.

Decomposition:
- The shared macro header holds:
  - FWD_DONT_FWD=0, FWD_EREG_TO_D=1, FWD_MREG_TO_D=2, FWD_MREG_TO_E=1, FWD_WREG_TO_E=2, FWD_WREG_TO_M=1.
  - TUSE_NONE=3.
- Sub-module md_busy_counter: inputs start, is_div; output busy. It is natural to separate because its lifetime is independent of flush.

Test Plan:
- Stall on load-use: lw $8 in E with tnew=2; D add reads rs=8 with tuse=1 -> stall=1 for 1 cycle. Next cycle M.tnew=1 with tuse 1 -> no stall. Cycle after that, fwd_e_rs=FWD_WREG_TO_E.
- Forward to D: addu $9 in E with tnew 0; D beq rs=9 with tuse 0 -> stall=0, fwd_d_rs=FWD_EREG_TO_D. Same instruction one cycle later in M -> FWD_MREG_TO_D.
- Register $0: E.dst=0, d_rs=0 -> fwd_d_rs=0, stall=0.
- Store data from W: lw $5 in W; sw with rt=5 in M -> fwd_m_rt=FWD_WREG_TO_M.
- mult then mfhi: stall=1 while mult is in E and for the 5 busy cycles, then 0. div gives 1+10 stall cycles.
- flush while lw $8 in E and D reads $8: no stall on the next cycle. Reset mid-div: busy_cnt=0, stall=0 immediately after.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared forwarding codes, pipeline record type and match helpers for hazard_ctrl.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  // Forwarding mux selects. Codes overlap between mux families on purpose:
  // each family decodes only its own subset.
  localparam logic [1:0] FWD_DONT_FWD  = 2'd0;
  localparam logic [1:0] FWD_EREG_TO_D = 2'd1;
  localparam logic [1:0] FWD_MREG_TO_D = 2'd2;
  localparam logic [1:0] FWD_MREG_TO_E = 2'd1;
  localparam logic [1:0] FWD_WREG_TO_E = 2'd2;
  localparam logic [1:0] FWD_WREG_TO_M = 2'd1;

  // Tuse value meaning "this operand is not read".
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // What the hazard unit remembers about one in-flight instruction.
  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       md_start;
    logic       md_is_div;
  } stage_rec_t;

  localparam stage_rec_t REC_EMPTY = '0;

  // Tnew counts down by one per stage and saturates at zero.
  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Record as it looks one stage further down the pipe.
  function automatic stage_rec_t age_rec(input stage_rec_t r);
    stage_rec_t a;
    a      = r;
    a.tnew = tnew_dec(r.tnew);
    return a;
  endfunction

  // Register 0 is hard-wired, so it can never be a producer/consumer match.
  function automatic logic reg_hit(input logic [4:0] idx, input logic [4:0] dst);
    return (idx != 5'd0) && (idx == dst);
  endfunction

  // A D-stage operand must wait when a producer in E or M cannot deliver
  // its value by the time D actually consumes it.
  function automatic logic src_stall(input logic [4:0] idx, input logic [1:0] tuse,
                                     input stage_rec_t e, input stage_rec_t m);
    if (tuse == TUSE_NONE) return 1'b0;
    return (reg_hit(idx, e.dst) && (tuse < e.tnew)) ||
           (reg_hit(idx, m.dst) && (tuse < m.tnew));
  endfunction

  // D-stage operand source; the nearest ready producer wins. W is not
  // listed because the register file writes through in the same cycle.
  function automatic logic [1:0] d_fwd_sel(input logic [4:0] idx,
                                           input stage_rec_t e, input stage_rec_t m);
    if (reg_hit(idx, e.dst) && (e.tnew == 2'd0)) return FWD_EREG_TO_D;
    if (reg_hit(idx, m.dst) && (m.tnew == 2'd0)) return FWD_MREG_TO_D;
    return FWD_DONT_FWD;
  endfunction

  // E-stage operand source, M preferred over W.
  function automatic logic [1:0] e_fwd_sel(input logic [4:0] idx,
                                           input stage_rec_t m, input stage_rec_t w);
    if (reg_hit(idx, m.dst) && (m.tnew == 2'd0)) return FWD_MREG_TO_E;
    if (reg_hit(idx, w.dst))                     return FWD_WREG_TO_E;
    return FWD_DONT_FWD;
  endfunction

  // M-stage store data can only be late relative to W.
  function automatic logic [1:0] m_fwd_sel(input logic [4:0] idx, input stage_rec_t w);
    return reg_hit(idx, w.dst) ? FWD_WREG_TO_M : FWD_DONT_FWD;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Multiply/divide busy timer: loads the unit's run length when an md op sits in E.
// Latency: busy asserts the cycle after start and stays for MULT_CYCLES/DIV_CYCLES cycles.
// Backpressure: none; only reset clears it, a pipeline flush does not stop the md unit.
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_MULT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] LOAD_DIV  = CW'(DIV_CYCLES);

  logic [CW-1:0] cnt;

  // Load on start, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= is_div ? LOAD_DIV : LOAD_MULT;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects for D/E/M muxes and the D-stage stall.
// Latency: outputs are combinational from E/M/W records and current D inputs.
// Backpressure: stall freezes F/D and inserts a bubble into E; M and W keep draining.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_is_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic [1:0] fwd_m_rt
);

  stage_rec_t d_rec;
  stage_rec_t e_rec;
  stage_rec_t m_rec;
  stage_rec_t w_rec;

  logic md_busy;
  logic stall_rs;
  logic stall_rt;
  logic stall_md;

  // Fields of the later stages that no consumer reads; kept in the record
  // so every stage has the same shape.
  logic unused_rec_bits;
  assign unused_rec_bits = ^{m_rec.rs, m_rec.md_start, m_rec.md_is_div,
                             w_rec.tnew, w_rec.rs, w_rec.rt,
                             w_rec.md_start, w_rec.md_is_div};

  assign d_rec = '{dst:       d_dst,
                   tnew:      d_tnew,
                   rs:        d_rs,
                   rt:        d_rt,
                   md_start:  d_md_start,
                   md_is_div: d_md_is_div};

  // Advance E->M->W every edge; on stall only E takes a bubble, on flush all clear.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      e_rec <= REC_EMPTY;
      m_rec <= REC_EMPTY;
      w_rec <= REC_EMPTY;
    end else begin
      e_rec <= stall ? REC_EMPTY : d_rec;
      m_rec <= age_rec(e_rec);
      w_rec <= age_rec(m_rec);
    end
  end

  // The md unit starts from the E stage and keeps running across flushes.
  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy (
    .clk    (clk),
    .reset  (reset),
    .start  (e_rec.md_start),
    .is_div (e_rec.md_is_div),
    .busy   (md_busy)
  );

  // Stall decision and forwarding selects from the records and D operands.
  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    stall_md = 1'b0;
    fwd_d_rs = FWD_DONT_FWD;
    fwd_d_rt = FWD_DONT_FWD;
    fwd_e_rs = FWD_DONT_FWD;
    fwd_e_rt = FWD_DONT_FWD;
    fwd_m_rt = FWD_DONT_FWD;

    stall_rs = src_stall(d_rs, d_tuse_rs, e_rec, m_rec);
    stall_rt = src_stall(d_rt, d_tuse_rt, e_rec, m_rec);
    // An md op already in E has not loaded the counter yet, so it blocks too.
    stall_md = d_md_use && (md_busy || e_rec.md_start);

    fwd_d_rs = d_fwd_sel(d_rs, e_rec, m_rec);
    fwd_d_rt = d_fwd_sel(d_rt, e_rec, m_rec);
    fwd_e_rs = e_fwd_sel(e_rec.rs, m_rec, w_rec);
    fwd_e_rt = e_fwd_sel(e_rec.rt, m_rec, w_rec);
    fwd_m_rt = m_fwd_sel(m_rec.rt, w_rec);
  end

  assign stall = stall_rs | stall_rt | stall_md;

endmodule
